// File: rtl/square_sched_pkg.sv
// Shared types for the time-multiplexed square voice scheduler.
// Voice context layout, scheduler states and default amplitude.
package square_sched_pkg;

    typedef struct packed {
        logic        active;
        int          sample;
        int          counter;
        logic [31:0] wave_length;
    } voice_ctx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int DEFAULT_AMPLITUDE = 1 << 20;

endpackage

// File: rtl/square_voice_ctx_store.sv
// Per-voice context registers: one combinational read port,
// a writeback port and a command port that overrides writeback.
module square_voice_ctx_store
    import square_sched_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AMPLITUDE  = DEFAULT_AMPLITUDE,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [VW-1:0]         rd_idx,
    output logic [31:0]           rd_sample,
    output logic [31:0]           rd_counter,
    output logic [31:0]           rd_wave_length,
    input  logic                  wb_en,
    input  logic [VW-1:0]         wb_idx,
    input  logic [31:0]           wb_sample,
    input  logic [31:0]           wb_counter,
    input  logic                  cmd_en,
    input  logic [VW-1:0]         cmd_idx,
    input  logic                  cmd_on,
    input  logic [31:0]           cmd_wave_length,
    output logic [NUM_VOICES-1:0] active_mask
);

    voice_ctx_t ctx [NUM_VOICES];
    logic       wb_hit;

    assign wb_hit = wb_en && !(cmd_en && (cmd_idx == wb_idx));

    assign rd_sample      = ctx[rd_idx].sample;
    assign rd_counter     = ctx[rd_idx].counter;
    assign rd_wave_length = ctx[rd_idx].wave_length;

    always_comb begin
        active_mask = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_mask[i] = ctx[i].active;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                ctx[i].active      <= 1'b0;
                ctx[i].sample      <= -AMPLITUDE;
                ctx[i].counter     <= 1;
                ctx[i].wave_length <= 32'd0;
            end
        end else begin
            if (wb_hit) begin
                ctx[wb_idx].sample  <= wb_sample;
                ctx[wb_idx].counter <= wb_counter;
            end
            if (cmd_en) begin
                // periods below 2 frames cannot toggle, so they stay silent
                if (cmd_on) begin
                    ctx[cmd_idx].active      <= (cmd_wave_length >= 32'd2);
                    ctx[cmd_idx].sample      <= -AMPLITUDE;
                    ctx[cmd_idx].counter     <= 1;
                    ctx[cmd_idx].wave_length <= cmd_wave_length;
                end else begin
                    ctx[cmd_idx].active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/square_voice_scheduler.sv
// Round-robin scheduler sharing one Square oscillator across voices,
// producing one signed mix sample per frame of NUM_VOICES cycles.
module square_voice_scheduler
    import square_sched_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AMPLITUDE  = DEFAULT_AMPLITUDE,
    parameter int VW         = $clog2(NUM_VOICES),
    parameter int SUM_W      = 32 + VW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [VW-1:0]         cmd_voice,
    input  logic                  cmd_on,
    input  logic [31:0]           cmd_wave_length,
    output logic                  osc_set,
    output logic [31:0]           osc_set_sample,
    output logic [31:0]           osc_set_counter,
    output logic [31:0]           osc_wave_length,
    input  logic [31:0]           osc_out,
    input  logic [31:0]           osc_counter,
    output logic                  mix_valid,
    output logic [SUM_W-1:0]      mix_out,
    output logic [NUM_VOICES-1:0] active_mask
);

    localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

    sched_state_t            state;
    logic [VW-1:0]           cur;
    logic [VW-1:0]           prev;
    logic                    prev_valid;
    logic                    kill;
    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] contrib;
    logic                    run;
    logic                    cmd_fire;
    logic                    wb_take;

    assign run       = (state == RUN);
    assign cmd_ready = run;
    assign osc_set   = run;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wb_take   = run && prev_valid && active_mask[prev] && !kill;
    assign contrib   = wb_take ? {{VW{osc_out[31]}}, osc_out} : '0;

    square_voice_ctx_store #(
        .NUM_VOICES(NUM_VOICES),
        .AMPLITUDE (AMPLITUDE),
        .VW        (VW)
    ) u_store (
        .clk            (clk),
        .reset_n        (reset_n),
        .rd_idx         (cur),
        .rd_sample      (osc_set_sample),
        .rd_counter     (osc_set_counter),
        .rd_wave_length (osc_wave_length),
        .wb_en          (wb_take),
        .wb_idx         (prev),
        .wb_sample      (osc_out),
        .wb_counter     (osc_counter),
        .cmd_en         (cmd_fire),
        .cmd_idx        (cmd_voice),
        .cmd_on         (cmd_on),
        .cmd_wave_length(cmd_wave_length),
        .active_mask    (active_mask)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            kill       <= 1'b0;
            acc        <= '0;
            mix_valid  <= 1'b0;
            mix_out    <= '0;
        end else begin
            mix_valid <= 1'b0;
            if (!run) begin
                state <= RUN;
            end else begin
                prev       <= cur;
                prev_valid <= 1'b1;
                cur        <= cur + 1'b1;
                // an in-flight voice must not overwrite a fresh command
                kill       <= cmd_fire && (cmd_voice == cur);
                if (prev_valid) begin
                    if (prev == LAST) begin
                        mix_out   <= acc + contrib;
                        mix_valid <= 1'b1;
                        acc       <= '0;
                    end else begin
                        acc <= acc + contrib;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_square_voice_scheduler.sv
// Scoreboard bench for square_voice_scheduler with four voices and a
// behavioural Square oscillator closing the osc_* loop.
module tb_square_voice_scheduler;

    localparam int     NV = 4;
    localparam longint A  = 1048576;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_voice;
    logic        cmd_on;
    logic [31:0] cmd_wave_length;
    logic        osc_set;
    logic [31:0] osc_set_sample;
    logic [31:0] osc_set_counter;
    logic [31:0] osc_wave_length;
    logic [31:0] osc_out;
    logic [31:0] osc_counter;
    logic        mix_valid;
    logic [33:0] mix_out;
    logic [3:0]  active_mask;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc;
    longint exp_q [$];
    longint last_mix = 0;

    // per frame: 0 none, -1 note-off, n>0 note-on with wave_length n
    int cmdt [19][4] = '{
        '{0, 0, 0, 0}, '{0, 8, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
        '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, -1, 0, 0}, '{8, 0, 8, 1},
        '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 8, 0, 0},
        '{0, 0, 0, 4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
        '{0, 0, 0, 0}, '{-1, 0, -1, 0}, '{0, -1, 0, 0}
    };
    int mixm [19] = '{0, -1, -1, -1, 1, 1, 0, -2, -2, -2,
                      2, 1, 0, 2, 0, -2, -2, 2, 1};
    logic [3:0] msk [19] = '{
        4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
        4'b0000, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0111,
        4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1010,
        4'b1000
    };

    square_voice_scheduler #(.NUM_VOICES(NV)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_voice      (cmd_voice),
        .cmd_on         (cmd_on),
        .cmd_wave_length(cmd_wave_length),
        .osc_set        (osc_set),
        .osc_set_sample (osc_set_sample),
        .osc_set_counter(osc_set_counter),
        .osc_wave_length(osc_wave_length),
        .osc_out        (osc_out),
        .osc_counter    (osc_counter),
        .mix_valid      (mix_valid),
        .mix_out        (mix_out),
        .active_mask    (active_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    // Square: flips after wave_length/2 frames, otherwise holds
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osc_out     <= '0;
            osc_counter <= '0;
        end else if (osc_set) begin
            if ($signed(osc_set_counter) >=
                $signed({1'b0, osc_wave_length[31:1]})) begin
                osc_out     <= -osc_set_sample;
                osc_counter <= 32'd1;
            end else begin
                osc_out     <= osc_set_sample;
                osc_counter <= osc_set_counter + 32'd1;
            end
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        int i;
        i = 0;
        while (cyc != target && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (cyc != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cyc: got %0d, expected %0d", cyc, target);
        end
    endtask

    initial begin
        longint e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_mix = 0;
            end else if (mix_valid) begin
                check("mix_cycle", (cyc < 5) ? -1 : (cyc - 5) % NV, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mix_unexpected: got %0d, expected none",
                             $signed(mix_out));
                end else begin
                    e = exp_q.pop_front();
                    check("mix_out", $signed(mix_out), e);
                end
                last_mix = $signed(mix_out);
            end else if (cyc > 5) begin
                check("mix_hold", $signed(mix_out), last_mix);
            end
        end
    end

    initial begin
        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_voice       = 2'd0;
        cmd_on          = 1'b0;
        cmd_wave_length = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_osc_set", osc_set, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_mix_out", mix_out, 0);
        check("rst_active_mask", active_mask, 0);
        exp_q.push_back(0);
        reset_n = 1'b1;

        wait_cyc(0);
        check("run_cmd_ready", cmd_ready, 1);
        check("run_osc_set", osc_set, 1);
        check("v0_sample", $signed(osc_set_sample), -A);
        check("v0_counter", osc_set_counter, 1);

        wait_cyc(2);
        for (int f = 0; f < 19; f++) begin
            exp_q.push_back(longint'(mixm[f]) * A);
            for (int v = 0; v < NV; v++) begin
                if (v == 0) check("cmd_ready", cmd_ready, 1);
                cmd_valid       = (cmdt[f][v] != 0);
                cmd_voice       = 2'(v);
                cmd_on          = (cmdt[f][v] > 0);
                cmd_wave_length = (cmdt[f][v] > 0) ? 32'(cmdt[f][v]) : 32'd0;
                @(negedge clk);
            end
            cmd_valid = 1'b0;
            check("active_mask", active_mask, msk[f]);
        end

        // voice 3 alone; frame 22 re-triggers it while in flight
        exp_q.push_back(-A);
        exp_q.push_back(-A);
        exp_q.push_back(0);
        exp_q.push_back(-A);
        exp_q.push_back(A);
        wait_cyc(91);
        check("v3_pre_counter", osc_set_counter, 2);
        cmd_valid       = 1'b1;
        cmd_voice       = 2'd3;
        cmd_on          = 1'b1;
        cmd_wave_length = 32'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_cyc(95);
        check("kill_sample", $signed(osc_set_sample), -A);
        check("kill_counter", osc_set_counter, 1);
        check("kill_wave_length", osc_wave_length, 4);
        check("kill_mask", active_mask, 4'b1000);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        wait_cyc(103);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_osc_set", osc_set, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_mix_valid", mix_valid, 0);
        check("mid_rst_mix_out", mix_out, 0);
        check("mid_rst_active_mask", active_mask, 0);
        @(negedge clk);
        exp_q.delete();
        repeat (3) exp_q.push_back(0);
        reset_n = 1'b1;
        wait_cyc(3);
        check("v3_rst_sample", $signed(osc_set_sample), -A);
        check("v3_rst_counter", osc_set_counter, 1);
        check("v3_rst_wave_length", osc_wave_length, 0);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mix_timeout: got %0d pending, expected 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/square_voice_scheduler.md
Name: square_voice_scheduler

Overview:
- Time-multiplexes one Square oscillator across NUM_VOICES voices.
- Each voice has its own context: sample, counter, wave_length and active flag.
- Each cycle the block loads one voice's context through the oscillator's set/set_sample/set_counter path, then writes the registered result back one cycle later.
- Accepts note commands through a valid/ready handshake and emits one signed mix sample per frame (NUM_VOICES cycles) to the audio output path.

Parameters:
- NUM_VOICES, 8, number of voice contexts; power of two, ≥2.
- AMPLITUDE, 1<<20, magnitude of a voice's sample at note-on.
- VW, $clog2(NUM_VOICES), voice index width.
- SUM_W, 32+VW, mix accumulator and output width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_voice  in  VW  target voice.
- cmd_on  in  1  1 = note-on, 0 = note-off.
- cmd_wave_length  in  32  period in frames; used by note-on only.
- osc_set  out  1  to Square set.
- osc_set_sample  out  32  to Square set_sample.
- osc_set_counter  out  32  to Square set_counter.
- osc_wave_length  out  32  to Square wave_length.
- osc_out  in  32  from Square out.
- osc_counter  in  32  from Square counter.
- mix_valid  out  1  one-cycle pulse per frame.
- mix_out  out  SUM_W  signed sum of active voice samples for the frame.
- active_mask  out  NUM_VOICES  per-voice active flag.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; cur = 0; prev_valid = 0; kill = 0; accumulator = 0.
  - Every context: active = 0, sample = -AMPLITUDE, counter = 1, wave_length = 0.
  - Outputs: osc_set = 0, cmd_ready = 0, mix_valid = 0, mix_out = 0, active_mask = 0.
- IDLE → RUN on the first clk edge with reset_n high. RUN is terminal until reset.
- RUN, cycle k (k = 0 is the first RUN cycle):
  - Present voice cur = k mod NUM_VOICES: osc_set = 1, and osc_set_sample, osc_set_counter, osc_wave_length come combinationally from context[cur].
  - At the edge, prev = cur and prev_valid = 1; cur increments and wraps from NUM_VOICES-1 to 0.
- Writeback, in each RUN cycle with prev_valid set:
  - If context[prev].active and !kill: context[prev].sample = osc_out, context[prev].counter = osc_counter.
  - Inactive voices are not written back; their phase is frozen.
- Mix:
  - The accumulator adds sign-extended osc_out when the voice being written back is active and !kill; otherwise it adds 0.
  - On writeback of voice NUM_VOICES-1: mix_out is registered with the final sum, mix_valid pulses high the next cycle, and the accumulator clears.
  - First mix_valid appears in RUN cycle NUM_VOICES+1, then every NUM_VOICES cycles. mix_out holds between pulses.
- Commands:
  - cmd_ready = 1 in RUN, 0 in IDLE.
  - Note-on: active = 1, sample = -AMPLITUDE, counter = 1, wave_length = cmd_wave_length.
  - Note-on with cmd_wave_length < 2 behaves as note-off (voice inactive, wave_length still stored).
  - Note-off: active = 0; sample and counter are kept.
  - The command takes effect at the accepting edge; active_mask reflects it the next cycle.
- Collisions:
  - Command targets the voice being written back this cycle: the command wins and the writeback is discarded.
  - Command targets cur (in flight): set kill = 1 for the next cycle. That voice's writeback and mix contribution are suppressed so the command is not overwritten.
  - kill clears after one cycle.
- Arithmetic: mix is signed, full precision, with no saturation. SUM_W covers NUM_VOICES × 32-bit with no overflow.
- Reset mid-frame: partial accumulator discarded, no mix_valid emitted, all voices inactive.

Decomposition:
- Package square_sched_pkg holds:
  - typedef voice_ctx_t {active, sample int, counter int, wave_length [31:0]};
  - enum sched_state_t {IDLE, RUN};
  - default AMPLITUDE constant.
- Sub-module square_voice_ctx_store: NUM_VOICES-entry register array.
  - One combinational read port (cur).
  - Writeback port and command port, with the command port taking priority on an address match.
- The Square instance lives in the parent; this block exposes only the osc_* interface.

Test Plan:
- NUM_VOICES=4, no commands → cmd_ready 0 then 1; mix_valid at RUN cycles 5, 9, 13 with mix_out = 0; osc_set 0 during reset, 1 after.
- Note-on voice 1, wave_length 8, with Square attached → mix_out = -1048576 for frames 1-3, +1048576 at frame 4, sign toggles every 4 frames thereafter.
- Note-on voices 0 and 2 with wave_length 8 in the same frame → mix_out = ±2097152 with no cancellation; add voice 3 with wave_length 4 → it toggles every 2 frames and the sums match the model.
- Note-off voice 1 mid-waveform, note-on 5 frames later → active_mask bit drops; voice 1 contributes 0 meanwhile and restarts from -AMPLITUDE, counter 1.
- Note-on issued while the target voice is cur (in flight) → next-cycle writeback suppressed; context equals the command values (sample -1048576, counter 1).
- Note-on with wave_length 1 → voice stays inactive, mix unaffected; reset_n pulsed mid-frame → all outputs return to reset values immediately, first mix_valid again at RUN cycle 5.
